// File: rtl/shifter_operand_pipe.sv
// Purpose  : ARM data-processing second operand (shifter_operand) and shifter carry-out, two-stage pipe.
// Latency  : request accepted at edge k gives out_valid=1 after edge k+1; one result per cycle.
// Backpress: out_valid held with out_ready=0 freezes Q/C_out/illegal; in_ready drops once both stages are full.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   in_valid / in_ready    request handshake (IR, RM, RS, C_in)
//   IR[31:0]               instruction; uses [27:25], [20], [11:0]
//   RM, RS [DATA_W-1:0]    Rm value, Rs value (only RS[7:0] used)
//   C_in                   current carry flag
//   out_valid / out_ready  result handshake (Q, C_out, illegal)
module shifter_operand_pipe #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       IR,
    input  logic [DATA_W-1:0] RM,
    input  logic [DATA_W-1:0] RS,
    input  logic              C_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Q,
    output logic              C_out,
    output logic              illegal
);
    localparam logic [8:0] LP_W = 9'(DATA_W);

    // Stage 1: only the instruction fields the shifter actually looks at.
    logic              r_s1_vld;
    logic [2:0]        r_s1_mode;
    logic              r_s1_sbit;
    logic [11:0]       r_s1_op;
    logic [DATA_W-1:0] r_s1_rm;
    logic [7:0]        r_s1_rs;
    logic              r_s1_cin;

    // Stage 2: registered result.
    logic              r_out_vld;
    logic [DATA_W-1:0] r_q;
    logic              r_c;
    logic              r_ill;

    logic              w_s1_load;
    logic              w_s2_load;

    // Unused instruction/Rs bits, gathered so the intent is explicit.
    logic w_unused_ir;
    assign w_unused_ir = ^{IR[31:28], IR[24:21], IR[19:12]};
    generate
        if (DATA_W > 8) begin : g_rs_hi
            logic w_unused_rs;
            assign w_unused_rs = ^RS[DATA_W-1:8];
        end
    endgenerate

    function automatic logic [DATA_W-1:0] f_ror(input logic [DATA_W-1:0] v, input logic [AMT_W-1:0] r);
        logic [2*DATA_W-1:0] t;
        t = {v, v} >> r;
        return t[DATA_W-1:0];
    endfunction

    assign w_s2_load = r_s1_vld && (!r_out_vld || out_ready);
    assign in_ready  = !r_s1_vld || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    // Shifter datapath
    logic [1:0]        w_typ;
    logic [4:0]        w_n;
    logic              w_msb;
    logic [7:0]        w_amt;
    logic [AMT_W-1:0]  w_amt_r;
    logic              w_ge;
    logic              w_eq;
    logic [DATA_W:0]   w_lsl_ext;   // carry lands in the extra top bit
    logic [DATA_W:0]   w_lsr_ext;   // carry lands in the extra bottom bit
    logic [DATA_W:0]   w_asr_ext;
    logic [DATA_W-1:0] w_ror;
    logic [AMT_W-1:0]  w_imm_rot;
    logic [DATA_W-1:0] w_imm_q;
    logic [DATA_W-1:0] w_q;
    logic              w_c;
    logic              w_ill;

    assign w_typ   = r_s1_op[6:5];
    assign w_n     = r_s1_op[11:7];
    assign w_msb   = r_s1_rm[DATA_W-1];
    // A non-zero immediate shift count behaves exactly like the same count held in Rs.
    assign w_amt   = r_s1_op[4] ? r_s1_rs : {3'b000, w_n};
    assign w_amt_r = w_amt[AMT_W-1:0];
    assign w_ge    = ({1'b0, w_amt} >= LP_W);
    assign w_eq    = ({1'b0, w_amt} == LP_W);

    assign w_lsl_ext = {1'b0, r_s1_rm} << w_amt_r;
    assign w_lsr_ext = {r_s1_rm, 1'b0} >> w_amt_r;
    assign w_asr_ext = $signed({r_s1_rm, 1'b0}) >>> w_amt_r;
    assign w_ror     = f_ror(r_s1_rm, w_amt_r);

    // Rotation of 2*IR[11:8] taken modulo the operand width.
    assign w_imm_rot = AMT_W'({r_s1_op[11:8], 1'b0});
    assign w_imm_q   = f_ror(DATA_W'(r_s1_op[7:0]), w_imm_rot);

    always_comb begin
        w_q   = '0;
        w_c   = r_s1_cin;
        w_ill = 1'b0;
        case (r_s1_mode)
            3'b001: begin
                w_q = w_imm_q;
                w_c = (r_s1_op[11:8] == 4'd0) ? r_s1_cin : w_imm_q[DATA_W-1];
            end
            3'b000: begin
                if (r_s1_op[4] && r_s1_op[7]) begin
                    w_ill = 1'b1;
                end else if (!r_s1_op[4] && (w_n == 5'd0)) begin
                    // Immediate count of zero: LSL #0, LSR #32, ASR #32, RRX
                    case (w_typ)
                        2'b00:   begin w_q = r_s1_rm;                        w_c = r_s1_cin;   end
                        2'b01:   begin w_q = '0;                             w_c = w_msb;      end
                        2'b10:   begin w_q = {DATA_W{w_msb}};                w_c = w_msb;      end
                        default: begin w_q = {r_s1_cin, r_s1_rm[DATA_W-1:1]}; w_c = r_s1_rm[0]; end
                    endcase
                end else if (w_amt == 8'd0) begin
                    w_q = r_s1_rm;
                    w_c = r_s1_cin;
                end else begin
                    case (w_typ)
                        2'b00: begin
                            if (!w_ge)     begin w_q = w_lsl_ext[DATA_W-1:0]; w_c = w_lsl_ext[DATA_W]; end
                            else if (w_eq) begin w_q = '0; w_c = r_s1_rm[0]; end
                            else           begin w_q = '0; w_c = 1'b0; end
                        end
                        2'b01: begin
                            if (!w_ge)     begin w_q = w_lsr_ext[DATA_W:1]; w_c = w_lsr_ext[0]; end
                            else if (w_eq) begin w_q = '0; w_c = w_msb; end
                            else           begin w_q = '0; w_c = 1'b0; end
                        end
                        2'b10: begin
                            if (!w_ge) begin w_q = w_asr_ext[DATA_W:1]; w_c = w_asr_ext[0]; end
                            else       begin w_q = {DATA_W{w_msb}};     w_c = w_msb;        end
                        end
                        default: begin
                            // Rotate by a multiple of the width leaves Rm intact but still sets C.
                            if (w_amt_r == '0) begin w_q = r_s1_rm; w_c = w_msb;              end
                            else               begin w_q = w_ror;   w_c = w_ror[DATA_W-1];    end
                        end
                    endcase
                end
            end
            default: w_ill = 1'b1;
        endcase
        if (!r_s1_sbit || w_ill) begin
            w_c = r_s1_cin;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= '0;
            r_s1_sbit <= 1'b0;
            r_s1_op   <= '0;
            r_s1_rm   <= '0;
            r_s1_rs   <= '0;
            r_s1_cin  <= 1'b0;
            r_out_vld <= 1'b0;
            r_q       <= '0;
            r_c       <= 1'b0;
            r_ill     <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_mode <= IR[27:25];
                r_s1_sbit <= IR[20];
                r_s1_op   <= IR[11:0];
                r_s1_rm   <= RM;
                r_s1_rs   <= RS[7:0];
                r_s1_cin  <= C_in;
            end
            if (w_s1_load)      r_s1_vld <= 1'b1;
            else if (w_s2_load) r_s1_vld <= 1'b0;

            if (w_s2_load) begin
                r_q       <= w_q;
                r_c       <= w_c;
                r_ill     <= w_ill;
                r_out_vld <= 1'b1;
            end else if (out_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign Q         = r_q;
    assign C_out     = r_c;
    assign illegal   = r_ill;
endmodule
